// File: rtl/video_line_scheduler_pkg.sv
// Shared types and timing helpers for the video line scheduler.
package video_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  // Full period of a blank-first timing counter, in counts.
  function automatic int calc_total(int res, int fp, int sync, int bp);
    return res + fp + sync + bp;
  endfunction

  // First (most negative) value of a blank-first timing counter.
  function automatic int calc_min(int fp, int sync, int bp);
    return -(fp + sync + bp);
  endfunction

endpackage

// File: rtl/video_line_scheduler_if.sv
// Line-buffer fill request bus towards the shared pixel memory.
interface video_line_scheduler_if #(
  parameter int ADDR_W = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic              fetch_done;

  modport master (output fetch_req, output fetch_addr, output fetch_done, input fetch_ack);
  modport slave  (input fetch_req, input fetch_addr, input fetch_done, output fetch_ack);
endinterface

// File: rtl/video_line_scheduler_sync_counter.sv
// Blank-first signed timing counter (MIN..RES-1) with a registered sync output.
module sync_counter
  import video_pkg::*;
#(
  parameter int RES   = 640,
  parameter int FP    = 16,
  parameter int SYNC  = 96,
  parameter int BP    = 48,
  parameter bit POL   = 1'b0,
  localparam int TOTAL = calc_total(RES, FP, SYNC, BP),
  localparam int W     = $clog2(TOTAL) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic signed [W-1:0] cnt,
  output logic                sync,
  output logic                wrap,
  output logic                at_min
);

  localparam logic signed [W-1:0] CNT_MIN = W'(calc_min(FP, SYNC, BP));
  localparam logic signed [W-1:0] CNT_MAX = W'(RES - 1);
  localparam logic signed [W-1:0] SYNC_LO = W'(-(SYNC + BP));
  localparam logic signed [W-1:0] SYNC_HI = W'(-BP);
  localparam logic signed [W-1:0] ONE     = W'(1);

  logic signed [W-1:0] cnt_q, cnt_d;
  logic                sync_q, sync_d;

  // Next count and next sync level from the current count.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MIN : cnt_q + ONE;
    end
    sync_d = ((cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI)) ? POL : ~POL;
  end

  // Counter and sync registers; sync therefore lags the count by one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_MIN;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt    = cnt_q;
  assign sync   = sync_q;
  assign wrap   = en && (cnt_q == CNT_MAX);
  assign at_min = (cnt_q == CNT_MIN);

endmodule

// File: rtl/video_line_scheduler.sv
// VGA timing generator plus per-line line-buffer fetch scheduler.
module video_line_scheduler
  import video_pkg::*;
#(
  parameter int H_RES          = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_RES          = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter bit H_POL          = 1'b0,
  parameter bit V_POL          = 1'b0,
  parameter int WORDS_PER_LINE = 20,
  parameter int ADDR_W         = 16,
  localparam int H_TOTAL       = calc_total(H_RES, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL       = calc_total(V_RES, V_FP, V_SYNC, V_BP),
  localparam int XW            = $clog2(H_TOTAL) + 1,
  localparam int YW            = $clog2(V_TOTAL) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank,
  output logic signed [XW-1:0] x,
  output logic signed [YW-1:0] y,
  output logic                 frame_start,
  video_line_scheduler_if.master fetch,
  output logic                 line_buf_sel,
  output logic                 underrun
);

  localparam int CW = $clog2(WORDS_PER_LINE + 1);
  localparam logic signed [XW-1:0] X_LAST_BLANK = '1;
  localparam logic signed [YW-1:0] Y_LAST       = YW'(V_RES - 1);
  localparam logic [CW-1:0]        LAST_WORD    = CW'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0]    LINE_STEP    = ADDR_W'(WORDS_PER_LINE);
  localparam logic [ADDR_W-1:0]    ADDR_ONE     = ADDR_W'(1);
  localparam logic [CW-1:0]        CNT_ONE      = CW'(1);

  logic h_wrap, h_at_min, v_at_min, v_wrap_unused;

  sync_counter #(.RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)) u_hcnt (
    .clk(clk), .rst(reset), .en(enable),
    .cnt(x), .sync(hsync), .wrap(h_wrap), .at_min(h_at_min)
  );

  sync_counter #(.RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)) u_vcnt (
    .clk(clk), .rst(reset), .en(h_wrap),
    .cnt(y), .sync(vsync), .wrap(v_wrap_unused), .at_min(v_at_min)
  );

  logic line_active, fetch_start, deadline;
  assign line_active = !y[YW-1] && (y <= Y_LAST);
  assign fetch_start = enable && h_at_min && line_active;
  assign deadline    = enable && (x == X_LAST_BLANK);
  assign frame_start = enable && h_at_min && v_at_min;
  assign blank       = x[XW-1] | y[YW-1];

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic              line_buf_sel_q, line_buf_sel_d;

  // Fetch burst sequencing, line base bookkeeping and buffer swap.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    underrun_d     = 1'b0;
    line_base_d    = line_base_q;
    line_buf_sel_d = line_buf_sel_q ^ (deadline && line_active);

    if (frame_start) begin
      line_base_d = '0;
    end else if ((state_q == IDLE) && fetch_start) begin
      line_base_d = line_base_q + LINE_STEP;
    end

    case (state_q)
      IDLE: begin
        if (fetch_start) begin
          state_d = REQ;
          addr_d  = line_base_q;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (fetch.fetch_ack) begin
          addr_d = addr_q + ADDR_ONE;
          cnt_d  = cnt_q + CNT_ONE;
        end
        // A final word landing on the deadline cycle completes the line.
        if (fetch.fetch_ack && (cnt_q == LAST_WORD)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (deadline) begin
          underrun_d = 1'b1;
          state_d    = IDLE;
        end
      end
    endcase
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
      line_base_q    <= '0;
      line_buf_sel_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      underrun_q     <= underrun_d;
      line_base_q    <= line_base_d;
      line_buf_sel_q <= line_buf_sel_d;
    end
  end

  assign fetch.fetch_req  = (state_q == REQ);
  assign fetch.fetch_addr = addr_q;
  assign fetch.fetch_done = done_q;
  assign underrun         = underrun_q;
  assign line_buf_sel     = line_buf_sel_q;

endmodule

// File: tb/tb_video_line_scheduler.sv
// Randomised bench for video_line_scheduler against a frame-position reference model.
module tb_video_line_scheduler;

  localparam int H_RES = 8, H_FP = 1, H_SYNC = 2, H_BP = 1;
  localparam int V_RES = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int WPL = 3, ADDR_W = 16;
  localparam int HT = 12, VT = 7, FT = 84, H_MIN = -4, V_MIN = -3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic hsync, vsync, blank, frame_start, line_buf_sel, underrun;
  logic signed [4:0] x;
  logic signed [3:0] y;

  video_line_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  video_line_scheduler #(
    .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(1'b0), .V_POL(1'b0), .WORDS_PER_LINE(WPL), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .hsync(hsync), .vsync(vsync), .blank(blank), .x(x), .y(y),
    .frame_start(frame_start), .fetch(bus.master),
    .line_buf_sel(line_buf_sel), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: position in frame counted in enable cycles.
  int t;
  bit b_act;
  int b_addr, b_left;
  bit e_done, e_und, e_sel, e_hs, e_vs;
  int fs_seen, sel_tog, und_seen, done_seen;
  logic last_sel;

  function automatic int cur_x();
    return H_MIN + (t % HT);
  endfunction

  function automatic int cur_y();
    return V_MIN + (t / HT);
  endfunction

  task automatic mdl_reset();
    t = 0; b_act = 0; b_addr = 0; b_left = 0;
    e_done = 0; e_und = 0; e_sel = 0; e_hs = 1; e_vs = 1;
    last_sel = 1'b0;
  endtask

  task automatic clear_stats();
    fs_seen = 0; sel_tog = 0; und_seen = 0; done_seen = 0;
  endtask

  // Drive one cycle's inputs at negedge, check, advance model, move to next negedge.
  task automatic step(input bit en, input bit ack);
    int cx, cy;
    bit line_act;
    enable = en;
    bus.fetch_ack = ack;
    #1;
    cx = cur_x();
    cy = cur_y();
    line_act = (cy >= 0) && (cy < V_RES);
    check("x", x, cx);
    check("y", y, cy);
    check("blank", blank, (cx < 0) || (cy < 0));
    check("hsync", hsync, e_hs);
    check("vsync", vsync, e_vs);
    check("frame_start", frame_start, en && (t == 0));
    check("fetch_req", bus.fetch_req, b_act);
    if (b_act) check("fetch_addr", bus.fetch_addr, b_addr);
    check("fetch_done", bus.fetch_done, e_done);
    check("underrun", underrun, e_und);
    check("line_buf_sel", line_buf_sel, e_sel);

    if (frame_start === 1'b1) fs_seen++;
    if (line_buf_sel !== last_sel) sel_tog++;
    last_sel = line_buf_sel;
    if (underrun === 1'b1) und_seen++;
    if (bus.fetch_done === 1'b1) done_seen++;

    e_hs = !((cx >= -(H_SYNC + H_BP)) && (cx < -H_BP));
    e_vs = !((cy >= -(V_SYNC + V_BP)) && (cy < -V_BP));
    e_done = 0;
    e_und = 0;
    if (b_act) begin
      if (ack) begin
        b_addr++;
        b_left--;
      end
      if (b_left == 0) begin
        e_done = 1;
        b_act = 0;
      end else if (en && cx == -1) begin
        e_und = 1;
        b_act = 0;
      end
    end else if (en && cx == H_MIN && line_act) begin
      b_act = 1;
      b_addr = cy * WPL;
      b_left = WPL;
    end
    if (en && cx == -1 && line_act) e_sel = !e_sel;
    if (en) t = (t + 1) % FT;

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fetch_ack = 1'b0;
    enable = 1'b1;
    reset = 1'b1;
    mdl_reset();
    clear_stats();
    @(negedge clk);
    @(negedge clk);
    check("rst_x", x, H_MIN);
    check("rst_y", y, V_MIN);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_blank", blank, 1);
    check("rst_req", bus.fetch_req, 0);
    check("rst_addr", bus.fetch_addr, 0);
    check("rst_sel", line_buf_sel, 0);
    check("rst_underrun", underrun, 0);
    check("rst_done", bus.fetch_done, 0);
    reset = 1'b0;

    // Two frames, memory always ready.
    clear_stats();
    repeat (2 * FT) step(1'b1, 1'b1);
    check("a_frame_starts", fs_seen, 2);
    check("a_sel_toggles", sel_tog, 8);
    check("a_underruns", und_seen, 0);
    check("a_dones", done_seen, 8);

    // Memory never ready: every active line underruns.
    clear_stats();
    repeat (FT) step(1'b1, 1'b0);
    check("b_underruns", und_seen, 4);
    check("b_dones", done_seen, 0);

    // Alternating enable, random acks.
    for (int i = 0; i < 4 * 2 * FT; i++) step((i % 2) == 0, $urandom_range(1, 0) == 1);

    // Fully random enable and ack.
    for (int i = 0; i < 1500; i++) step($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1);

    // Reset in the middle of a burst.
    for (int i = 0; i < 200 && !b_act; i++) step(1'b1, 1'b0);
    check("req_before_reset", bus.fetch_req, 1);
    reset = 1'b1;
    #1;
    check("midrst_req", bus.fetch_req, 0);
    check("midrst_addr", bus.fetch_addr, 0);
    check("midrst_x", x, H_MIN);
    check("midrst_y", y, V_MIN);
    mdl_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Ack only on the deadline cycle of line 2.
    clear_stats();
    for (int i = 0; i < FT; i++) step(1'b1, b_act && cur_x() == -1 && cur_y() == 2);
    check("f_underruns", und_seen, 4);
    check("f_dones", done_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
